// File: rtl/bus_master_port.sv
// Requester-side bus port: requests the bus from the arbiter, runs the address
// and data phases of one burst, then releases the bus and reports status.
module bus_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_ack,
  output logic                  BARQ,
  input  logic                  BAGD,
  output logic                  AddressValid,
  output logic [ADDR_WIDTH-1:0] BusAddr,
  input  logic                  TargetReady,
  output logic                  DataStrobe,
  output logic [DATA_WIDTH-1:0] BusData,
  output logic                  done,
  output logic [2:0]            Error
);

  localparam int            CW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_GNT  = 3'd1;
  localparam logic [2:0] ERR_TGT  = 3'd2;
  localparam logic [2:0] ERR_LOST = 3'd3;

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, RELEASE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            err_q, err_d;
  logic                  barq_q, avalid_q, data_q, rdy_q, done_q;
  logic                  beat_fire;

  // A data beat is the same-cycle TargetReady handshake while we still hold
  // the grant; a lost grant suppresses the strobe in that very cycle.
  assign beat_fire = data_q & BAGD & TargetReady;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    len_d   = len_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          state_d = REQ;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          err_d   = ERR_OK;
          cnt_d   = '0;
          beat_d  = '0;
        end
      end
      REQ: begin
        if (BAGD) begin
          state_d = ADDR;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          state_d = RELEASE;
          err_d   = ERR_GNT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADDR: begin
        if (!BAGD) begin
          state_d = RELEASE;
          err_d   = ERR_LOST;
        end else if (TargetReady) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          state_d = RELEASE;
          err_d   = ERR_TGT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (!BAGD) begin
          state_d = RELEASE;
          err_d   = ERR_LOST;
        end else if (TargetReady) begin
          cnt_d = '0;
          // Compare before incrementing so len=all-ones never wraps the beat count.
          if (beat_q == len_q) state_d = RELEASE;
          else                 beat_d  = beat_q + 1'b1;
        end else if (cnt_q == TMO) begin
          state_d = RELEASE;
          err_d   = ERR_TGT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!BAGD) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      err_q    <= ERR_OK;
      barq_q   <= 1'b0;
      avalid_q <= 1'b0;
      data_q   <= 1'b0;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      barq_q   <= (state_d == REQ) || (state_d == ADDR) || (state_d == DATA);
      avalid_q <= (state_d == ADDR);
      data_q   <= (state_d == DATA);
      rdy_q    <= (state_d == IDLE);
      done_q   <= (state_d == RELEASE) && (state_q != RELEASE);
    end
  end

  assign cmd_ready    = rdy_q;
  assign BARQ         = barq_q;
  assign AddressValid = avalid_q;
  assign BusAddr      = addr_q;
  assign DataStrobe   = beat_fire;
  assign wr_data_ack  = beat_fire;
  assign BusData      = beat_fire ? wr_data : '0;
  assign done         = done_q;
  assign Error        = err_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed scenarios plus random
// bursts, each checked cycle by cycle against a per-transaction timeline model.
module tb_bus_master_port;
  localparam int AW = 16, DW = 16, LW = 4, TMO = 8, MAXT = 256, SEQ = 200;

  logic          clk = 1'b0, Reset = 1'b1;
  logic          cmd_valid, cmd_ready, wr_data_ack, BARQ, BAGD, AddressValid;
  logic          TargetReady, DataStrobe, done;
  logic [AW-1:0] cmd_addr, BusAddr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, BusData;
  logic [2:0]    Error;

  always #5 clk = ~clk;

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_data_ack(wr_data_ack),
    .BARQ(BARQ), .BAGD(BAGD), .AddressValid(AddressValid), .BusAddr(BusAddr),
    .TargetReady(TargetReady), .DataStrobe(DataStrobe), .BusData(BusData),
    .done(done), .Error(Error)
  );

  int checks = 0, errors = 0;
  int last_err = 0, ds_cnt = 0, ack_cnt = 0;

  // Stimulus plan and expectations, indexed by cycle t relative to the first REQ cycle.
  bit            tr_seq [SEQ];
  logic [DW-1:0] wdata  [17];
  bit            d_bagd [MAXT];
  bit            d_tr   [MAXT];
  bit            e_ds   [MAXT];
  int            e_widx [MAXT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Data-phase TargetReady pattern: per beat a run of stalls then one ready cycle.
  // Beat lb gets exactly ll stalls; the others get 0..maxs.
  task automatic gen_seq(input int len, input int lb, input int ll, input int maxs);
    int k, s;
    k = 0;
    for (int i = 0; i < SEQ; i++) tr_seq[i] = 1'b1;
    for (int b = 0; b <= len; b++) begin
      s = (b == lb) ? ll : int'($urandom_range(0, maxs));
      for (int z = 0; z < s && k < SEQ - 1; z++) begin
        tr_seq[k] = 1'b0;
        k++;
      end
      k++;
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input int len, input int gdly,
                         input int adly, input int drop_j, input int rdly, input int gap);
    int ga, e, err, t0, aend, r, beats, run, j, last, cnt;
    bit fin, av_exp;
    for (int i = 0; i < MAXT; i++) begin
      d_bagd[i] = 1'b0;
      d_tr[i]   = ($urandom_range(0, 1) == 1);
      e_ds[i]   = 1'b0;
    end
    for (int i = 0; i < 17; i++) wdata[i] = DW'($urandom);
    ga = -1; t0 = -1; aend = -1; err = 0; e = 0;
    if (gdly > TMO) begin
      e = TMO; err = 1;                       // REQ lasts TIMEOUT+1 cycles
    end else begin
      ga = gdly;
      if (adly > TMO) begin
        e = ga + 1 + TMO; err = 2; aend = e;  // ADDR lasts TIMEOUT+1 cycles
        for (int t = ga + 1; t <= e; t++) d_tr[t] = 1'b0;
      end else begin
        for (int t = ga + 1; t <= ga + adly; t++) d_tr[t] = 1'b0;
        d_tr[ga + adly + 1] = 1'b1;
        t0 = ga + adly + 2; aend = t0 - 1;
        beats = 0; run = 0; j = 0; fin = 1'b0;
        while (!fin && j < SEQ) begin
          d_tr[t0 + j] = tr_seq[j];
          if (j == drop_j) begin
            err = 3; e = t0 + j; fin = 1'b1;
          end else if (tr_seq[j]) begin
            e_ds[t0 + j] = 1'b1; beats++; run = 0;
            if (beats == len + 1) begin e = t0 + j; fin = 1'b1; end
          end else begin
            run++;
            if (run == TMO + 1) begin err = 2; e = t0 + j; fin = 1'b1; end
          end
          j++;
        end
      end
      last = (err == 3) ? e - 1 : e + rdly;
      for (int t = ga; t <= last; t++) d_bagd[t] = 1'b1;
    end
    r = d_bagd[e] ? e + 1 + rdly : e + 1;     // last cycle spent in RELEASE
    cnt = 0;
    for (int t = 0; t < MAXT; t++) begin
      e_widx[t] = cnt;
      if (e_ds[t]) cnt++;
    end

    repeat (gap) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; BAGD = 1'b0; TargetReady = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_barq", 32'(BARQ), 32'd0);
      chk("idle_error", 32'(Error), 32'(last_err));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = LW'(len); BAGD = 1'b0; TargetReady = 1'b0;
    @(negedge clk);
    chk("accept_ready", 32'(cmd_ready), 32'd1);

    for (int t = 0; t <= r + 1; t++) begin
      @(posedge clk); #1;
      cmd_valid   = (t <= r) ? ($urandom_range(0, 1) == 1) : 1'b0;
      cmd_addr    = AW'($urandom);
      cmd_len     = LW'($urandom);
      BAGD        = d_bagd[t];
      TargetReady = d_tr[t];
      wr_data     = wdata[(e_widx[t] > 16) ? 16 : e_widx[t]];
      @(negedge clk);
      av_exp = (ga >= 0) && (t >= ga + 1) && (t <= aend);
      ds_cnt  += int'(DataStrobe);
      ack_cnt += int'(wr_data_ack);
      chk("barq", 32'(BARQ), 32'(t <= e));
      chk("addr_valid", 32'(AddressValid), 32'(av_exp));
      if (av_exp) chk("bus_addr", 32'(BusAddr), 32'(addr));
      chk("data_strobe", 32'(DataStrobe), 32'(e_ds[t]));
      chk("wr_data_ack", 32'(wr_data_ack), 32'(e_ds[t]));
      if (e_ds[t]) chk("bus_data", 32'(BusData), 32'(wdata[e_widx[t]]));
      chk("done", 32'(done), 32'(t == e + 1));
      chk("cmd_ready", 32'(cmd_ready), 32'(t == r + 1));
      chk("error", 32'(Error), 32'((t <= e) ? 0 : err));
    end
    last_err = err;
  endtask

  initial begin
    int len, gd, ad, dr, lb, ll;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
    BAGD = 1'b0; TargetReady = 1'b0;

    // Reset values
    #3 Reset = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_barq", 32'(BARQ), 32'd0);
    chk("rst_av", 32'(AddressValid), 32'd0);
    chk("rst_ds", 32'(DataStrobe), 32'd0);
    chk("rst_ack", 32'(wr_data_ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_busaddr", 32'(BusAddr), 32'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1'b1;

    // Single write, grant two cycles after BARQ
    gen_seq(0, -1, 0, 0);
    run_txn(16'h1234, 0, 2, 0, -1, 1, 1);

    // Burst of four beats with TargetReady 1,0,0,1,1,0,1
    begin
      logic [0:6] p;
      p = 7'b1001101;
      for (int i = 0; i < SEQ; i++) tr_seq[i] = 1'b1;
      for (int i = 0; i < 7; i++) tr_seq[i] = p[i];
    end
    ds_cnt = 0; ack_cnt = 0;
    run_txn(16'h0040, 3, 0, 0, -1, 0, 1);
    chk("burst_strobes", 32'(ds_cnt), 32'd4);
    chk("burst_acks", 32'(ack_cnt), 32'd4);

    // Grant timeout, target timeout in ADDR, grant lost after beat 3
    run_txn(16'h0100, 2, TMO + 1, 0, -1, 0, 1);
    run_txn(16'h0200, 2, 0, TMO + 1, -1, 2, 1);
    gen_seq(7, -1, 0, 0);
    ds_cnt = 0;
    run_txn(16'h0300, 7, 1, 0, 3, 0, 1);
    chk("lost_strobes", 32'(ds_cnt), 32'd3);

    // Boundaries: longest burst, grant/target at exactly TIMEOUT, stall of exactly TIMEOUT
    gen_seq(15, 5, TMO, 1);
    ds_cnt = 0;
    run_txn(16'hFFFF, 15, TMO, TMO, -1, 1, 0);
    chk("max_burst_strobes", 32'(ds_cnt), 32'd16);
    gen_seq(4, 2, TMO + 1, 1);
    run_txn(16'h0400, 4, 0, 0, -1, 1, 1);

    // Random bursts
    for (int n = 0; n < 40; n++) begin
      len = int'($urandom_range(0, 15));
      gd  = ($urandom_range(0, 7) == 0) ? TMO + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      ad  = ($urandom_range(0, 7) == 0) ? TMO + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      lb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      ll  = TMO + int'($urandom_range(0, 1));
      dr  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1;
      gen_seq(len, lb, ll, 3);
      run_txn(AW'($urandom), len, gd, ad, dr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a data phase
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 16'hBEEF; cmd_len = 4'd3; BAGD = 1'b0; TargetReady = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; BAGD = 1'b1;
    @(posedge clk); #1;
    TargetReady = 1'b1;
    @(negedge clk);
    chk("arst_pre_av", 32'(AddressValid), 32'd1);
    @(posedge clk); #1;
    wr_data = 16'h55AA;
    @(negedge clk);
    chk("arst_pre_ds", 32'(DataStrobe), 32'd1);
    chk("arst_pre_barq", 32'(BARQ), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_barq", 32'(BARQ), 32'd0);
    chk("arst_av", 32'(AddressValid), 32'd0);
    chk("arst_ds", 32'(DataStrobe), 32'd0);
    @(posedge clk); #1;
    Reset = 1'b1; BAGD = 1'b0; TargetReady = 1'b0;
    @(negedge clk);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_error", 32'(Error), 32'd0);
    last_err = 0;

    // Normal operation resumes after reset
    gen_seq(2, -1, 0, 2);
    run_txn(16'h0ABC, 2, 1, 1, -1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
Requester-side bus interface that sits directly upstream of the bus arbiter. It accepts a burst command from local logic and raises BARQ, waits for BAGD, and then runs the address and data phases using the AddressValid / TargetReady / DataStrobe handshake. It releases the bus when the burst finishes and reports completion or error status. One instance drives one BARQ/BAGD pair of the arbiter.

Parameters:
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 16, bus data width
LEN_WIDTH, 4, burst length field width; a burst is cmd_len+1 beats (1..2^LEN_WIDTH)
TIMEOUT, 255, maximum wait cycles for grant or target before an error is declared (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  LEN_WIDTH  beats minus one
wr_data  in  DATA_WIDTH  next beat data, must be valid whenever state is DATA
wr_data_ack  out  1  pulse: current wr_data consumed
BARQ  out  1  bus request to arbiter
BAGD  in  1  bus grant from arbiter
AddressValid  out  1  address phase strobe
BusAddr  out  ADDR_WIDTH  latched address
TargetReady  in  1  target handshake
DataStrobe  out  1  data beat strobe
BusData  out  DATA_WIDTH  beat data
done  out  1  one-cycle pulse at end of transaction
Error  out  3  status code, valid from done until next command accepted

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; all outputs 0 except cmd_ready=1; Error=0; counters cleared. Reset asserted mid-transfer drops BARQ/AddressValid/DataStrobe immediately.
- All outputs are registered. The arbiter sees BARQ one cycle after command acceptance.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch cmd_addr and cmd_len, clear Error and the wait counter, go to REQ.
- REQ: BARQ=1. BAGD sampled 1 -> ADDR, counter cleared. Otherwise counter increments; counter==TIMEOUT -> Error=1 (grant timeout), go to RELEASE.
- ADDR: BARQ=1, AddressValid=1, BusAddr=latched address. TargetReady=1 -> DATA, counter cleared. Counter==TIMEOUT -> Error=2 (target timeout), go to RELEASE.
- DATA: BARQ=1, AddressValid=0.
  - In each cycle with TargetReady=1: DataStrobe=1 and BusData=wr_data for that cycle; wr_data_ack=1 in the same cycle; beat counter increments; stall counter is cleared.
  - TargetReady=0: DataStrobe=0 and the stall counter increments. Stall counter==TIMEOUT -> Error=2, go to RELEASE.
  - Last beat (beat count==cmd_len) strobed -> go to RELEASE with Error=0.
- Grant lost: BAGD=0 while in ADDR or DATA -> Error=3, go to RELEASE; no strobe in that cycle. BAGD loss has priority over TargetReady and over timeout in the same cycle.
- RELEASE: BARQ=0, AddressValid=0, DataStrobe=0; done=1 for exactly one cycle on entry.
  - Stay in RELEASE while BAGD=1; this is required so the arbiter can retract the grant.
  - BAGD=0 -> IDLE.
  - A new command is not accepted until IDLE.
- Error codes: 0 ok, 1 grant timeout, 2 target timeout, 3 grant lost, 4–7 reserved (never driven).
- Counter width is ceil(log2(TIMEOUT+1)); counters saturate and do not wrap.
- cmd_len=0 gives a single beat. cmd_len=all-ones gives 2^LEN_WIDTH beats, with no overflow of the beat counter compare.

Test Plan:
- Single write: cmd_addr=0x1234, cmd_len=0, BAGD high 2 cycles after BARQ, TargetReady high immediately -> one DataStrobe carrying wr_data; done=1, Error=0; BARQ low the cycle after the strobe.
- Burst with stalls: cmd_len=3, TargetReady pattern 1,0,0,1,1,0,1 -> exactly 4 DataStrobe pulses and 4 wr_data_ack pulses, aligned with TargetReady=1; done=1, Error=0.
- Grant timeout: TIMEOUT=8, BAGD held 0 -> BARQ high 9 cycles, then done=1, Error=1, cmd_ready returns to 1.
- Target timeout: BAGD=1, TargetReady held 0 in ADDR -> done=1, Error=2 after TIMEOUT+1 ADDR cycles; no DataStrobe.
- Grant lost mid-burst: cmd_len=7, BAGD dropped after beat 3 -> no further strobes; done=1, Error=3; IDLE on the next cycle since BAGD=0.
- Async reset during DATA: Reset pulled low between clock edges -> BARQ, AddressValid and DataStrobe go to 0 without a clock edge; after release, cmd_ready=1 and Error=0.
